// File: rtl/gate_lab_pkg.sv
// rtl/gate_lab_pkg.sv - shared types and truth-table constants for 2-input gate checking
package gate_lab_pkg;

  localparam int NUM_VECTORS = 4;

  // Truth tables indexed by {a,b}: bit0 = 00 ... bit3 = 11
  localparam logic [NUM_VECTORS-1:0] TT_NAND = 4'b0111;
  localparam logic [NUM_VECTORS-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VECTORS-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VECTORS-1:0] TT_NOR  = 4'b0001;
  localparam logic [NUM_VECTORS-1:0] TT_XOR  = 4'b0110;
  localparam logic [NUM_VECTORS-1:0] TT_XNOR = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/settle_counter.sv
// rtl/settle_counter.sv - settle-window counter with load, enable and terminal count
module settle_counter #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  // The count only needs to reach SETTLE_CYCLES-1; terminal count fires on that last cycle.
  localparam int unsigned W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 32'd0);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == LAST);

endmodule

// File: rtl/gate_truth_checker.sv
// rtl/gate_truth_checker.sv - drives a 2-input gate through all vectors and checks its truth table
module gate_truth_checker
  import gate_lab_pkg::*;
#(
  parameter int unsigned            SETTLE_CYCLES = 2,
  parameter logic [NUM_VECTORS-1:0] EXPECTED      = TT_NAND
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   gate_a,
  output logic                   gate_b,
  input  logic                   gate_y,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [NUM_VECTORS-1:0] fail_mask,
  output logic [1:0]             vector_idx
);

  state_e                   state_q, state_d;
  logic [1:0]               vec_q, vec_d;
  logic [NUM_VECTORS-1:0]   mask_q, mask_d;
  logic                     pass_q, pass_d;
  logic                     cnt_load;
  logic                     cnt_en;
  logic                     cnt_tc;

  settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .load_i(cnt_load),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    mask_d   = mask_q;
    pass_d   = pass_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          vec_d   = 2'd0;
          mask_d  = '0;
          pass_d  = 1'b0;
        end
      end
      ST_DRIVE: begin
        cnt_load = 1'b1;
        state_d  = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
      end
      ST_SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_tc) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        mask_d[vec_q] = (gate_y != EXPECTED[vec_q]);
        if (vec_q == 2'd3) begin
          // pass must already reflect the last vector while done is high
          state_d = ST_DONE;
          pass_d  = (mask_d == '0);
        end else begin
          state_d = ST_DRIVE;
          vec_d   = vec_q + 2'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        vec_d   = 2'd0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= 2'd0;
      mask_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
    end
  end

  assign gate_a     = vec_q[1];
  assign gate_b     = vec_q[0];
  assign vector_idx = vec_q;
  assign busy       = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign fail_mask  = mask_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// tb/tb_gate_truth_checker.sv - bench for gate_truth_checker with gate models around four instances
module tb_gate_truth_checker;
  import gate_lab_pkg::*;

  typedef struct packed {
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] mask;
    logic [1:0] idx;
  } obs_t;

  typedef struct {
    int         inst;
    logic [3:0] mask;
    logic       pass;
    int         cycle;
  } exp_t;

  localparam int S_TAB [4] = '{2, 0, 1, 3};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start_r;
  int         gate_mode;
  int         checks = 0;
  int         failures = 0;
  exp_t       sb [$];

  logic       a0, b0, y0, busy0, done0, pass0;
  logic       a1, b1, y1, busy1, done1, pass1;
  logic       a2, b2, y2, busy2, done2, pass2;
  logic       a3, b3, y3, busy3, done3, pass3;
  logic [3:0] m0, m1, m2, m3;
  logic [1:0] i0, i1, i2, i3;
  logic [2:0] dly2 = 3'b111;
  logic [2:0] dly3 = 3'b111;
  obs_t       obs [4];

  always #5 clk = ~clk;

  // Gate models: instance 0 switchable, 1 good NAND, 2/3 NAND whose output lags 3 edges
  always_comb begin
    case (gate_mode)
      0:       y0 = ~(a0 & b0);
      1:       y0 = a0 & b0;
      default: y0 = (a0 & b0) ? 1'b1 : ~(a0 & b0);
    endcase
  end
  assign y1 = ~(a1 & b1);
  always @(posedge clk) begin
    dly2 <= {dly2[1:0], ~(a2 & b2)};
    dly3 <= {dly3[1:0], ~(a3 & b3)};
  end
  assign y2 = dly2[2];
  assign y3 = dly3[2];

  gate_truth_checker #(.SETTLE_CYCLES(2), .EXPECTED(TT_NAND)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .gate_a(a0), .gate_b(b0), .gate_y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .fail_mask(m0), .vector_idx(i0));
  gate_truth_checker #(.SETTLE_CYCLES(0), .EXPECTED(TT_NAND)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .gate_a(a1), .gate_b(b1), .gate_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_mask(m1), .vector_idx(i1));
  gate_truth_checker #(.SETTLE_CYCLES(1), .EXPECTED(TT_NAND)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]), .gate_a(a2), .gate_b(b2), .gate_y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .fail_mask(m2), .vector_idx(i2));
  gate_truth_checker #(.SETTLE_CYCLES(3), .EXPECTED(TT_NAND)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_r[3]), .gate_a(a3), .gate_b(b3), .gate_y(y3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_mask(m3), .vector_idx(i3));

  assign obs[0] = {a0, b0, busy0, done0, pass0, m0, i0};
  assign obs[1] = {a1, b1, busy1, done1, pass1, m1, i1};
  assign obs[2] = {a2, b2, busy2, done2, pass2, m2, i2};
  assign obs[3] = {a3, b3, busy3, done3, pass3, m3, i3};

  function automatic logic [3:0] exp_mask(input int mode);
    logic [3:0] m;
    logic [3:0] tt;
    logic       a, b, y;
    tt = TT_NAND;
    for (int i = 0; i < 4; i++) begin
      a = (i >= 2);
      b = (i % 2) == 1;
      case (mode)
        0:       y = !(a && b);
        1:       y = a && b;
        default: y = 1'b1;
      endcase
      m[i] = (y != tt[i]);
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic run_check(input int inst, input logic [3:0] exp_m, input bit hold, input bit poke);
    int   s, dc, c, ei;
    bit   seen;
    exp_t e;
    obs_t o;
    s = S_TAB[inst];
    dc = 4 * (s + 2) + 1;
    e.inst = inst;
    e.mask = exp_m;
    e.pass = (exp_m == 4'd0);
    e.cycle = dc;
    sb.push_back(e);
    start_r[inst] = 1'b1;
    seen = 1'b0;
    c = 0;
    while (!seen && c < dc + 8) begin
      @(negedge clk);
      c++;
      if (!hold && c == 1) start_r[inst] = 1'b0;
      if (poke && c == 5) start_r[inst] = 1'b1;
      if (poke && c == 6) start_r[inst] = 1'b0;
      o = obs[inst];
      if (c == 1) check("accept_clear", 32'({o.pass, o.mask}), 32'd0);
      if (o.done) begin
        seen = 1'b1;
        e = sb.pop_front();
        check("done_cycle", c, e.cycle);
        check("result", 32'({o.busy, o.pass, o.mask}), 32'({1'b0, e.pass, e.mask}));
        if (poke) start_r[inst] = 1'b1;
      end else begin
        ei = (c - 1) / (s + 2);
        check("stim", 32'({o.busy, o.idx, o.a, o.b}), 32'({1'b1, ei[1:0], ei[1:0]}));
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (!seen) e = sb.pop_front();
    @(negedge clk);
    if (poke) start_r[inst] = 1'b0;
    o = obs[inst];
    check("post_done", 32'({o.busy, o.done, o.idx, o.a, o.b, o.pass, o.mask}),
          32'({6'd0, e.pass, e.mask}));
  endtask

  initial begin
    obs_t o;
    bit   any_done;
    rst_n = 1'b0;
    start_r = 4'd0;
    gate_mode = 0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) check("reset", 32'(obs[i]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_check(0, exp_mask(0), 1'b0, 1'b0);
    gate_mode = 1;
    run_check(0, exp_mask(1), 1'b0, 1'b0);
    gate_mode = 2;
    run_check(0, exp_mask(2), 1'b0, 1'b0);
    gate_mode = 0;
    run_check(1, exp_mask(0), 1'b0, 1'b0);

    run_check(0, 4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    check("poke_ignored", 32'({busy0, done0}), 32'd0);

    // start held across DONE: re-arms from IDLE and clears the failing mask
    gate_mode = 1;
    run_check(0, 4'b1111, 1'b1, 1'b0);
    gate_mode = 0;
    run_check(0, 4'b0000, 1'b0, 1'b0);

    start_r[0] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start_r[0] = 1'b0;
    end
    check("pre_abort", 32'({busy0, i0}), 32'({1'b1, 2'd2}));
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_reset", 32'(obs[0]), 32'd0);
    rst_n = 1'b1;
    any_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      o = obs[0];
      any_done = any_done | o.done | o.busy;
    end
    check("no_done_after_abort", 32'(any_done), 32'd0);
    run_check(0, 4'b0000, 1'b0, 1'b0);

    run_check(2, 4'b1000, 1'b0, 1'b0);
    run_check(3, 4'b0000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
